// File: rtl/z_pack_pkg.sv
// Shared definitions for the z packer: word geometry, slot boundaries and FSM encoding.
// The slot constants are also used by the seek_cd consumer.
package z_pack_pkg;

    localparam int Datawidth   = 32;
    localparam int ZW          = 2 * Datawidth + 2;
    localparam int IW          = Datawidth + 1;
    localparam int ZP_WAIT_MAX = 15;

    localparam int S0_MSB = 65;
    localparam int S0_LSB = 59;
    localparam int S1_MSB = 58;
    localparam int S1_LSB = 46;
    localparam int S2_MSB = 45;
    localparam int S2_LSB = 33;
    localparam int S3_MSB = 32;
    localparam int S3_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_WAIT    = 2'd3
    } zp_state_e;

    // Right-justified mask covering the legal bits of the slot addressed by a beat index.
    function automatic logic [IW-1:0] slot_mask(input logic [1:0] beat);
        logic [IW-1:0] ones;
        int            width;
        ones = '1;
        case (beat)
            2'd0:    width = S0_MSB - S0_LSB + 1;
            2'd1:    width = S1_MSB - S1_LSB + 1;
            2'd2:    width = S2_MSB - S2_LSB + 1;
            default: width = S3_MSB - S3_LSB + 1;
        endcase
        return ones >> (IW - width);
    endfunction

endpackage

// File: rtl/zpack_wdog.sv
// WAIT-state timeout counter: flags expiry when rdy has not arrived within ZP_WAIT_MAX cycles.
// Only instantiated when ZPACK_WATCHDOG_EN is defined.
module zpack_wdog
    import z_pack_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic rdy,
    output logic expire
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = run ? cnt_q + 4'd1 : 4'd0;
    end

    // cnt_q holds the number of WAIT cycles already elapsed, so expiry fires on the last allowed one.
    assign expire = run && !rdy && (cnt_q == 4'(ZP_WAIT_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/z_pack.sv
// Sequential packer: gathers four field beats into the 66-bit word z and hands it to seek_cd.
// Optional WAIT watchdog enabled by defining ZPACK_WATCHDOG_EN.
module z_pack
    import z_pack_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    output logic [ZW-1:0] z,
    output logic          en,
    input  logic          rdy,
    output logic          busy,
    output logic          err_ovf,
    output logic          err_to
);

    zp_state_e     state_q, state_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [ZW-1:0] z_q, z_d;
    logic          in_ready_q, in_ready_d;
    logic          err_ovf_q, err_ovf_d;
    logic          wd_expire;
    logic          xfer;
    logic [IW-1:0] mask;
    logic [IW-1:0] fld;

    assign xfer = in_valid && in_ready_q;
    assign mask = slot_mask(bcnt_q);
    assign fld  = in_data & mask;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        z_d       = z_q;
        err_ovf_d = err_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (xfer && bcnt_q == 2'd3) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rdy || wd_expire) begin
                    state_d = ST_IDLE;
                    bcnt_d  = 2'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Truncated value is still accepted; the overflow is only recorded.
        if (xfer) begin
            bcnt_d    = bcnt_q + 2'd1;
            err_ovf_d = err_ovf_q | (|(in_data & ~mask));
            case (bcnt_q)
                2'd0:    z_d[S0_MSB:S0_LSB] = fld[S0_MSB-S0_LSB:0];
                2'd1:    z_d[S1_MSB:S1_LSB] = fld[S1_MSB-S1_LSB:0];
                2'd2:    z_d[S2_MSB:S2_LSB] = fld[S2_MSB-S2_LSB:0];
                default: z_d[S3_MSB:S3_LSB] = fld[S3_MSB-S3_LSB:0];
            endcase
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= 2'd0;
            z_q        <= '0;
            in_ready_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            z_q        <= z_d;
            in_ready_q <= in_ready_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

`ifdef ZPACK_WATCHDOG_EN
    logic err_to_q;

    zpack_wdog u_wdog (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == ST_WAIT),
        .rdy    (rdy),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_to_q <= 1'b0;
        end else begin
            err_to_q <= err_to_q | wd_expire;
        end
    end

    assign err_to = err_to_q;
`else
    assign wd_expire = 1'b0;
    assign err_to    = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign z        = z_q;
    assign en       = (state_q == ST_ISSUE);
    assign busy     = (state_q != ST_IDLE);
    assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_z_pack.sv
// Directed bench for z_pack: packing, overflow, gaps, stale rdy, reset abort and WAIT behaviour.
// Inputs change on the falling edge or just after the rising edge; outputs are sampled on the falling edge.
module tb_z_pack;
    import z_pack_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [ZW-1:0] z;
    logic          en;
    logic          rdy;
    logic          busy;
    logic          err_ovf;
    logic          err_to;

    int checks = 0;
    int errors = 0;

    z_pack dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .z        (z),
        .en       (en),
        .rdy      (rdy),
        .busy     (busy),
        .err_ovf  (err_ovf),
        .err_to   (err_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one beat from a falling edge; returns on the falling edge after the transfer.
    task automatic put(input logic [IW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("put_ready_timeout", ZW'(n < 20), ZW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_word(input string tag, input logic [ZW-1:0] exp_z);
        // Called in the ISSUE cycle: one WAIT cycle with rdy, then IDLE.
        @(negedge clk);
        chk({tag, "_wait_en"}, ZW'(en), ZW'(0));
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk({tag, "_idle_busy"}, ZW'(busy), ZW'(0));
        chk({tag, "_idle_z"}, z, exp_z);
    endtask

    logic [ZW-1:0] zexp;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        rdy      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_z", z, '0);
        chk("rst_en", ZW'(en), ZW'(0));
        chk("rst_in_ready", ZW'(in_ready), ZW'(0));
        chk("rst_busy", ZW'(busy), ZW'(0));
        chk("rst_err_ovf", ZW'(err_ovf), ZW'(0));
        chk("rst_err_to", ZW'(err_to), ZW'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", ZW'(in_ready), ZW'(1));

        // Basic pack, with a beat offered during ISSUE and WAIT that must not be taken
        zexp = {7'h55, 13'h1ABC, 13'h0123, 33'h1_2345_6789};
        put(33'h55);
        chk("basic_collect_busy", ZW'(busy), ZW'(1));
        put(33'h1ABC);
        put(33'h0123);
        put(33'h1_2345_6789);
        chk("basic_issue_en", ZW'(en), ZW'(1));
        chk("basic_issue_ready", ZW'(in_ready), ZW'(0));
        chk("basic_z", z, zexp);
        in_valid = 1'b1;
        in_data  = 33'h1_FFFF_FFFF;
        @(negedge clk);
        chk("basic_wait_en", ZW'(en), ZW'(0));
        chk("basic_wait_ready", ZW'(in_ready), ZW'(0));
        chk("basic_wait_busy", ZW'(busy), ZW'(1));
        rdy = 1'b1;
        @(negedge clk);
        rdy      = 1'b0;
        in_valid = 1'b0;
        chk("basic_idle_busy", ZW'(busy), ZW'(0));
        chk("basic_idle_ready", ZW'(in_ready), ZW'(1));
        chk("basic_hold_z", z, zexp);
        chk("basic_no_ovf", ZW'(err_ovf), ZW'(0));

        // Overflow on beat 0
        zexp = {7'h7F, 13'h0001, 13'h0002, 33'h0_0000_0003};
        put(33'h0FF);
        chk("ovf_flag", ZW'(err_ovf), ZW'(1));
        put(33'h1);
        put(33'h2);
        put(33'h3);
        chk("ovf_issue_en", ZW'(en), ZW'(1));
        chk("ovf_z", z, zexp);
        finish_word("ovf", zexp);
        chk("ovf_sticky", ZW'(err_ovf), ZW'(1));

        // Gaps in COLLECT plus a stale rdy pulse
        zexp = {7'h12, 13'h0AAA, 13'h1555, 33'h0_DEAD_BEEF};
        put(33'h12);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        chk("stale_rdy_busy", ZW'(busy), ZW'(1));
        chk("stale_rdy_ready", ZW'(in_ready), ZW'(1));
        put(33'h0AAA);
        @(negedge clk);
        put(33'h1555);
        repeat (3) @(negedge clk);
        chk("gap_no_issue", ZW'(en), ZW'(0));
        put(33'h0_DEAD_BEEF);
        chk("gap_issue_en", ZW'(en), ZW'(1));
        chk("gap_z", z, zexp);
        finish_word("gap", zexp);

        // Reset after beat 2 aborts the word
        put(33'h01);
        put(33'h0002);
        put(33'h0003);
        reset = 1'b1;
        #1;
        chk("abort_z", z, '0);
        chk("abort_busy", ZW'(busy), ZW'(0));
        chk("abort_ready", ZW'(in_ready), ZW'(0));
        chk("abort_ovf_clr", ZW'(err_ovf), ZW'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_en", ZW'(en), ZW'(0));
        zexp = {7'h3C, 13'h0F0F, 13'h10F0, 33'h1_0000_0001};
        put(33'h3C);
        put(33'h0F0F);
        put(33'h10F0);
        put(33'h1_0000_0001);
        chk("after_abort_en", ZW'(en), ZW'(1));
        chk("after_abort_z", z, zexp);
        finish_word("after_abort", zexp);

        // rdy withheld in WAIT
        zexp = {7'h01, 13'h0010, 13'h0100, 33'h0_0000_1000};
        put(33'h01);
        put(33'h0010);
        put(33'h0100);
        put(33'h1000);
        chk("wd_issue_en", ZW'(en), ZW'(1));
`ifdef ZPACK_WATCHDOG_EN
        repeat (15) @(negedge clk);
        chk("wd_last_wait_busy", ZW'(busy), ZW'(1));
        chk("wd_last_wait_to", ZW'(err_to), ZW'(0));
        @(negedge clk);
        chk("wd_expired_busy", ZW'(busy), ZW'(0));
        chk("wd_expired_to", ZW'(err_to), ZW'(1));
        chk("wd_expired_z", z, zexp);
`else
        repeat (20) @(negedge clk);
        chk("nowd_busy", ZW'(busy), ZW'(1));
        chk("nowd_ready", ZW'(in_ready), ZW'(0));
        chk("nowd_to", ZW'(err_to), ZW'(0));
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("nowd_idle", ZW'(busy), ZW'(0));
        chk("nowd_z", z, zexp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
